serial_to_parallel_receiver: RTL and testbench

Receiving end of the shift-register serial link. It collects a serial bit stream of the kind a universal shift register emits when shifting, and reassembles it into WIDTH-bit parallel words. Completed words are presented through a registered Valid/Ready output buffer. It sits between the serial link and any parallel consumer (register file, ALU operand latch).

---
 rtl/serial_to_parallel_receiver_pkg.sv | 15 +
 rtl/deser_shift_core.sv | 56 +++++
 rtl/serial_to_parallel_receiver.sv | 91 +++++++++
 tb/tb_serial_to_parallel_receiver.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_receiver_pkg.sv
// Shared encodings and defaults for the serial-to-parallel receiver.
// Holds the FSM state type, the bit-order codes and the default word length.
package serial_to_parallel_receiver_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_e;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/deser_shift_core.sv
// Shift register plus bit counter for the receiver.
// Exposes the combinational next word and a flag marking the frame's final bit.
module deser_shift_core
    import serial_to_parallel_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             restart,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_word,
    output logic             last_bit
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_base;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_d;

    // A restart discards the partial frame before the current bit is shifted in.
    always_comb begin
        sh_base  = restart ? '0 : sh_q;
        cnt_base = restart ? '0 : cnt_q;
        next_word = sh_base;
        if (shift_en) begin
            if (dir == DIR_MSB_FIRST) begin
                next_word = {sh_base[WIDTH-2:0], ser_in};
            end else begin
                next_word = {ser_in, sh_base[WIDTH-1:1]};
            end
        end
        last_bit = shift_en && (cnt_base == LAST_CNT);
        cnt_d    = cnt_base;
        if (shift_en) begin
            cnt_d = last_bit ? '0 : cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= next_word;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_to_parallel_receiver.sv
// Serial link receiver: frames serial bits into WIDTH-bit words and presents
// them through a single-entry Valid/Ready buffer with a sticky overrun flag.
module serial_to_parallel_receiver
    import serial_to_parallel_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Dir,
    input  logic             SerValid,
    input  logic             SerIn,
    input  logic             Ready,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Busy,
    output logic             Overrun
);

    state_e           state_q;
    logic             dir_q;
    logic [WIDTH-1:0] q_q;
    logic             valid_q;
    logic             busy_q;
    logic             overrun_q;

    logic             shift_en;
    logic             eff_dir;
    logic [WIDTH-1:0] next_word;
    logic             last_bit;

    // Start samples Dir directly so a bit arriving alongside Start uses the new order.
    always_comb begin
        shift_en = SerValid && (Start || (state_q == ST_RECV));
        eff_dir  = Start ? Dir : dir_q;
    end

    deser_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (CLK),
        .clear     (Clear),
        .shift_en  (shift_en),
        .dir       (eff_dir),
        .restart   (Start),
        .ser_in    (SerIn),
        .next_word (next_word),
        .last_bit  (last_bit)
    );

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_LSB_FIRST;
            q_q       <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (Start) begin
                state_q <= ST_RECV;
                busy_q  <= 1'b1;
                dir_q   <= Dir;
            end else if ((state_q == ST_RECV) && last_bit) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end

            // A full buffer that is not being drained drops the new word.
            if (last_bit) begin
                if (!valid_q || Ready) begin
                    q_q     <= next_word;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && Ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Q       = q_q;
    assign Valid   = valid_q;
    assign Busy    = busy_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Self-checking bench for serial_to_parallel_receiver: directed scenarios plus
// randomized traffic compared against a frame-level reference model.
module tb_serial_to_parallel_receiver;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         Clear, Start, Dir, SerValid, SerIn, Ready;
    logic [W-1:0] Q;
    logic         Valid, Busy, Overrun;

    int compared   = 0;
    int mismatched = 0;

    serial_to_parallel_receiver #(
        .WIDTH (W),
        .CNT_W (2)
    ) dut (
        .CLK      (CLK),
        .Clear    (Clear),
        .Start    (Start),
        .Dir      (Dir),
        .SerValid (SerValid),
        .SerIn    (SerIn),
        .Ready    (Ready),
        .Q        (Q),
        .Valid    (Valid),
        .Busy     (Busy),
        .Overrun  (Overrun)
    );

    always #5 CLK = ~CLK;

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic st, input logic d, input logic sv, input logic si,
                         input logic rdy);
        Clear = 1'b0; Start = st; Dir = d; SerValid = sv; SerIn = si; Ready = rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        Clear = 1'b1; Start = 1'b0; SerValid = 1'b0; SerIn = 1'b0; Ready = 1'b0;
        @(posedge CLK);
        #1;
        Clear = 1'b0;
    endtask

    // Send a complete word as a frame: Start cycle, then W bits in the given order.
    task automatic send_word(input logic [W-1:0] word, input logic d, input logic rdy);
        drive(1'b1, d, 1'b0, 1'b0, rdy);
        for (int i = 0; i < W; i++) begin
            drive(1'b0, 1'b0, 1'b1, d ? word[W-1-i] : word[i], rdy);
        end
    endtask

    task automatic test_reset();
        Clear = 1'b1; Start = 1'b1; Dir = 1'b1; SerValid = 1'b1; SerIn = 1'b1; Ready = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        compared++;
        if ({Q, Valid, Busy, Overrun} !== '0) begin
            mismatched++;
            $display("FAIL reset: Q=%b V=%b B=%b O=%b, required all 0", Q, Valid, Busy, Overrun);
        end
        Clear = 1'b0;
    endtask

    task automatic test_lsb_basic();
        logic [3:0] bits;
        do_clear();
        bits = 4'b1010;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, bits[i], 1'b1);
        compared++;
        if (Q !== 4'b1010 || Valid !== 1'b1) begin
            mismatched++;
            $display("FAIL lsb_word: Q=%b V=%b, required Q=1010 V=1", Q, Valid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compared++;
        if (Valid !== 1'b0) begin
            mismatched++;
            $display("FAIL lsb_consume: V=%b, required 0", Valid);
        end
    endtask

    task automatic test_msb_gaps();
        logic [3:0] bits;
        do_clear();
        bits = 4'b1010;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (Busy !== 1'b1) begin
                mismatched++;
                $display("FAIL msb_busy: bit %0d Busy=%b, required 1", i, Busy);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i < 3) begin
                compared++;
                if (Busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL msb_gap_busy: after gap %0d Busy=%b, required 1", i, Busy);
                end
            end
            if (i == 3) break;
            drive(1'b0, 1'b0, 1'b1, bits[3-i], 1'b0);
            if (i == 2) begin
                drive(1'b0, 1'b0, 1'b1, bits[0], 1'b0);
                break;
            end
        end
        compared++;
        if (Q !== 4'b1010 || Valid !== 1'b1 || Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL msb_word: Q=%b V=%b B=%b, required Q=1010 V=1 B=0", Q, Valid, Busy);
        end
    endtask

    task automatic test_overrun();
        do_clear();
        send_word(4'b0011, 1'b0, 1'b0);
        send_word(4'b1100, 1'b0, 1'b0);
        compared++;
        if (Q !== 4'b0011 || Valid !== 1'b1 || Overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_drop: Q=%b V=%b O=%b, required Q=0011 V=1 O=1",
                     Q, Valid, Overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compared++;
        if (Valid !== 1'b0 || Overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_sticky: V=%b O=%b, required V=0 O=1", Valid, Overrun);
        end
        do_clear();
        compared++;
        if (Overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL overrun_clear: O=%b, required 0", Overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w2;
        do_clear();
        w2 = 4'b0110;
        send_word(4'b0011, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, w2[i], i == 3);
        compared++;
        if (Q !== 4'b0110 || Valid !== 1'b1 || Overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_word: Q=%b V=%b O=%b, required Q=0110 V=1 O=0",
                     Q, Valid, Overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compared++;
        if (Valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_consume: V=%b, required 0", Valid);
        end
    endtask

    task automatic test_restart();
        do_clear();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        compared++;
        if (Busy !== 1'b1 || Valid !== 1'b0) begin
            mismatched++;
            $display("FAIL restart_busy: B=%b V=%b, required B=1 V=0", Busy, Valid);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        compared++;
        if (Q !== 4'b1111 || Valid !== 1'b1 || Overrun !== 1'b0 || Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL restart_word: Q=%b V=%b O=%b B=%b, required Q=1111 V=1 O=0 B=0",
                     Q, Valid, Overrun, Busy);
        end
    endtask

    task automatic test_clear_midframe();
        do_clear();
        send_word(4'b1001, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_clear();
        compared++;
        if ({Q, Valid, Busy, Overrun} !== '0) begin
            mismatched++;
            $display("FAIL clear_mid: Q=%b V=%b B=%b O=%b, required all 0",
                     Q, Valid, Busy, Overrun);
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        compared++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || Q !== 4'b0000) begin
            mismatched++;
            $display("FAIL idle_ignore: Q=%b V=%b B=%b, required Q=0000 V=0 B=0",
                     Q, Valid, Busy);
        end
    endtask

    // Reference model: collects the frame's bits in arrival order and builds the
    // word by weighting bit i as 2^i (LSB-first) or 2^(W-1-i) (MSB-first).
    task automatic test_random(input int cycles);
        int           n;
        int           bits [W];
        logic         in_frame, mdir, m_valid, m_over, done, xfer;
        logic [W-1:0] m_q, word;
        logic         c, st, d, sv, si, rdy;
        do_clear();
        n = 0; in_frame = 0; mdir = 0; m_valid = 0; m_over = 0; m_q = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            c   = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 9) == 0);
            d   = 1'($urandom_range(0, 1));
            sv  = ($urandom_range(0, 9) < 6);
            si  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            if (c) begin
                n = 0; in_frame = 0; mdir = 0; m_valid = 0; m_over = 0; m_q = '0;
            end else begin
                done = 0;
                word = '0;
                xfer = m_valid && rdy;
                if (st) begin
                    in_frame = 1; n = 0; mdir = d;
                end
                if (sv && in_frame) begin
                    bits[n] = int'(si);
                    n++;
                    if (n == W) begin
                        done = 1;
                        in_frame = 0;
                        for (int i = 0; i < W; i++) begin
                            word = word + W'(bits[i] << (mdir ? (W - 1 - i) : i));
                        end
                        n = 0;
                    end
                end
                if (done) begin
                    if (!m_valid || rdy) begin
                        m_q = word; m_valid = 1;
                    end else begin
                        m_over = 1;
                    end
                end else if (xfer) begin
                    m_valid = 0;
                end
            end
            Clear = c; Start = st; Dir = d; SerValid = sv; SerIn = si; Ready = rdy;
            @(posedge CLK);
            #1;
            compared++;
            if (Q !== m_q || Valid !== m_valid || Busy !== in_frame || Overrun !== m_over) begin
                mismatched++;
                if (mismatched < 20)
                    $display("FAIL random cyc %0d: Q=%b V=%b B=%b O=%b, required Q=%b V=%b B=%b O=%b",
                             cyc, Q, Valid, Busy, Overrun, m_q, m_valid, in_frame, m_over);
            end
        end
        Clear = 1'b0;
    endtask

    initial begin
        Clear = 1'b1; Start = 1'b0; Dir = 1'b0; SerValid = 1'b0; SerIn = 1'b0; Ready = 1'b0;
        test_reset();
        test_lsb_basic();
        test_msb_gaps();
        test_overrun();
        test_back_to_back();
        test_restart();
        test_clear_midframe();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
